// File: rtl/alu_display_seq_pkg.sv
// Shared types and constants for the ALU board front-end:
// FSM encoding, view selector codes and the hex segment table.
package alu_display_seq_pkg;

  typedef enum logic [1:0] {
    ENTER_A = 2'b00,
    ENTER_B = 2'b01,
    EXEC    = 2'b10,
    SHOW    = 2'b11
  } state_e;

  localparam logic [1:0] VIEW_AUTO = 2'd0;
  localparam logic [1:0] VIEW_A    = 2'd1;
  localparam logic [1:0] VIEW_B    = 2'd2;
  localparam logic [1:0] VIEW_RES  = 2'd3;

  // Active-high {g,f,e,d,c,b,a}, entry 0 rightmost.
  localparam logic [15:0][6:0] SEG_LUT = {
    7'h71, 7'h79, 7'h5E, 7'h39,
    7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66,
    7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  function automatic logic [6:0] hex_to_seg(
    input logic [3:0] nib
  );
    return SEG_LUT[nib];
  endfunction

endpackage

// File: rtl/alu_display_seq_if.sv
// Board and ALU signal bundle for the front-end.
// master = front-end side, slave = board/ALU side.
interface alu_display_seq_if #(
  parameter int DATA_W = 16
);
  localparam int DIGITS = DATA_W / 4;

  logic [3:0]        nibble_in;
  logic              enter;
  logic              clear;
  logic [3:0]        opcode_in;
  logic              cin_in;
  logic [1:0]        view_sel;
  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  logic [3:0]        alu_opcode;
  logic              alu_cin;
  logic [DATA_W-1:0] alu_result;
  logic [4:0]        alu_flags;
  logic [DATA_W-1:0] result_out;
  logic [4:0]        flags_out;
  logic              result_valid;
  logic [1:0]        state_out;
  logic [6:0]        seg_out;
  logic [DIGITS-1:0] an_out;

  modport master (
    input  nibble_in, enter, clear,
    input  opcode_in, cin_in, view_sel,
    input  alu_result, alu_flags,
    output alu_a, alu_b, alu_opcode, alu_cin,
    output result_out, flags_out,
    output result_valid, state_out,
    output seg_out, an_out
  );

  modport slave (
    output nibble_in, enter, clear,
    output opcode_in, cin_in, view_sel,
    output alu_result, alu_flags,
    input  alu_a, alu_b, alu_opcode, alu_cin,
    input  result_out, flags_out,
    input  result_valid, state_out,
    input  seg_out, an_out
  );

endinterface

// File: rtl/seven_seg_scan.sv
// Multiplexed seven-segment scanner: one digit lit at a time,
// segments and anode registered together to avoid ghosting.
module seven_seg_scan
  import alu_display_seq_pkg::*;
#(
  parameter int DIGITS         = 4,
  parameter int REFRESH_DIV    = 50000,
  parameter int SEG_ACTIVE_LOW = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [4*DIGITS-1:0] value_i,
  output logic [6:0]          seg_o,
  output logic [DIGITS-1:0]   an_o
);

  localparam int CW =
    (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IW =
    (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic INV = (SEG_ACTIVE_LOW != 0);

  logic [CW-1:0]     cnt_q, cnt_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [6:0]        seg_q, seg_d;
  logic [DIGITS-1:0] an_q, an_d;
  logic [3:0]        nib;

  // Next refresh count, digit index and the pattern for that digit.
  always_comb begin
    cnt_d = cnt_q + CW'(1);
    idx_d = idx_q;
    if (cnt_q == CW'(REFRESH_DIV - 1)) begin
      cnt_d = '0;
      if (idx_q == IW'(DIGITS - 1)) begin
        idx_d = '0;
      end else begin
        idx_d = idx_q + IW'(1);
      end
    end
    nib  = '0;
    an_d = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_d == IW'(i)) begin
        nib     = value_i[4*i +: 4];
        an_d[i] = 1'b1;
      end
    end
    seg_d = hex_to_seg(nib);
  end

  // Scan state and display registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
      idx_q <= '0;
      seg_q <= hex_to_seg(4'h0);
      an_q  <= DIGITS'(1);
    end else begin
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      seg_q <= seg_d;
      an_q  <= an_d;
    end
  end

  assign seg_o = INV ? ~seg_q : seg_q;
  assign an_o  = INV ? ~an_q  : an_q;

endmodule

// File: rtl/alu_display_seq.sv
// Board front-end for the ALU: nibble-wise operand entry,
// one-cycle execute, result latch and scanned hex display.
module alu_display_seq
  import alu_display_seq_pkg::*;
#(
  parameter int DATA_W         = 16,
  parameter int REFRESH_DIV    = 50000,
  parameter int SEG_ACTIVE_LOW = 1
) (
  input logic               clk,
  input logic               reset,
  alu_display_seq_if.master bus
);

  localparam int DIGITS = DATA_W / 4;
  localparam int NW     = $clog2(DIGITS + 1);

  state_e            state_q, state_d;
  logic [NW-1:0]     cnt_q, cnt_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic [3:0]        op_q, op_d;
  logic              cin_q, cin_d;
  logic [DATA_W-1:0] res_q, res_d;
  logic [4:0]        flg_q, flg_d;
  logic              vld_q, vld_d;
  logic [DATA_W-1:0] disp;
  logic              last_nib;
  logic [DATA_W-1:0] nib_ext;

  assign last_nib = (cnt_q == NW'(DIGITS - 1));
  assign nib_ext  = DATA_W'(bus.nibble_in);

  // Entry FSM: clear overrides everything, enter drives progress.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    cin_d   = cin_q;
    res_d   = res_q;
    flg_d   = flg_q;
    vld_d   = vld_q;
    if (bus.clear) begin
      state_d = ENTER_A;
      cnt_d   = '0;
      a_d     = '0;
      b_d     = '0;
      res_d   = '0;
      flg_d   = '0;
      vld_d   = 1'b0;
    end else begin
      unique case (state_q)
        ENTER_A: begin
          if (bus.enter) begin
            a_d = (a_q << 4) | nib_ext;
            if (last_nib) begin
              cnt_d   = '0;
              state_d = ENTER_B;
            end else begin
              cnt_d = cnt_q + NW'(1);
            end
          end
        end
        ENTER_B: begin
          if (bus.enter) begin
            b_d = (b_q << 4) | nib_ext;
            if (last_nib) begin
              cnt_d   = '0;
              op_d    = bus.opcode_in;
              cin_d   = bus.cin_in;
              state_d = EXEC;
            end else begin
              cnt_d = cnt_q + NW'(1);
            end
          end
        end
        EXEC: begin
          res_d   = bus.alu_result;
          flg_d   = bus.alu_flags;
          vld_d   = 1'b1;
          state_d = SHOW;
        end
        SHOW: begin
          if (bus.enter) begin
            a_d     = nib_ext;
            b_d     = '0;
            cnt_d   = NW'(1);
            vld_d   = 1'b0;
            state_d = ENTER_A;
          end
        end
        default: state_d = ENTER_A;
      endcase
    end
  end

  // FSM and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ENTER_A;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      cin_q   <= 1'b0;
      res_q   <= '0;
      flg_q   <= '0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      cin_q   <= cin_d;
      res_q   <= res_d;
      flg_q   <= flg_d;
      vld_q   <= vld_d;
    end
  end

  // Pick the value shown on the display.
  always_comb begin
    disp = res_q;
    unique case (bus.view_sel)
      VIEW_A:   disp = a_q;
      VIEW_B:   disp = b_q;
      VIEW_RES: disp = res_q;
      default: begin
        unique case (state_q)
          ENTER_A: disp = a_q;
          ENTER_B: disp = b_q;
          default: disp = res_q;
        endcase
      end
    endcase
  end

  seven_seg_scan #(
    .DIGITS         (DIGITS),
    .REFRESH_DIV    (REFRESH_DIV),
    .SEG_ACTIVE_LOW (SEG_ACTIVE_LOW)
  ) u_scan (
    .clk     (clk),
    .reset   (reset),
    .value_i (disp),
    .seg_o   (bus.seg_out),
    .an_o    (bus.an_out)
  );

  assign bus.alu_a        = a_q;
  assign bus.alu_b        = b_q;
  assign bus.alu_opcode   = op_q;
  assign bus.alu_cin      = cin_q;
  assign bus.result_out   = res_q;
  assign bus.flags_out    = flg_q;
  assign bus.result_valid = vld_q;
  assign bus.state_out    = state_q;

endmodule

// File: tb/tb_alu_display_seq.sv
// Directed bench for alu_display_seq with result and
// scan scoreboards fed by the stimulus process.
module tb_alu_display_seq;

  typedef struct {
    logic [15:0] res;
    logic [4:0]  flg;
  } res_exp_t;

  typedef struct {
    logic [3:0] an;
    logic [6:0] seg;
  } scan_exp_t;

  localparam logic [6:0] S0 = 7'h40;
  localparam logic [6:0] S2 = 7'h24;
  localparam logic [6:0] S4 = 7'h19;
  localparam logic [6:0] SE = 7'h06;
  localparam logic [6:0] SB = 7'h03;

  logic clk = 1'b0;
  logic reset;
  int   n_vec = 0;
  int   n_err = 0;

  res_exp_t  res_q[$];
  scan_exp_t scan_q[$];

  alu_display_seq_if #(.DATA_W(16)) bus();

  alu_display_seq #(
    .DATA_W         (16),
    .REFRESH_DIV    (4),
    .SEG_ACTIVE_LOW (1)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  assign bus.alu_result =
    bus.alu_a + bus.alu_b + {15'b0, bus.alu_cin};
  assign bus.alu_flags = 5'b00010;

  task automatic chk(
    input string       name,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic enter_nib(input logic [3:0] n);
    bus.nibble_in = n;
    bus.enter     = 1'b1;
    step();
    bus.enter     = 1'b0;
  endtask

  task automatic wait_an(
    input  logic [3:0] target,
    input  string      name
  );
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (bus.an_out === target) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    chk(name, {31'b0, ok}, 32'd1);
  endtask

  // Result monitor: compare on each rising result_valid.
  logic prev_v = 1'b0;
  always @(negedge clk) begin
    res_exp_t e;
    if (bus.result_valid === 1'b1 &&
        prev_v !== 1'b1) begin
      if (res_q.size() == 0) begin
        chk("res_unexpected", 32'd1, 32'd0);
      end else begin
        e = res_q.pop_front();
        chk("res_val", 32'(bus.result_out),
            32'(e.res));
        chk("res_flg", 32'(bus.flags_out),
            32'(e.flg));
      end
    end
    prev_v = bus.result_valid;
  end

  // Scan monitor: compare on each anode change, with hold time.
  logic [3:0] prev_an = 4'b1110;
  int         hold = 0;
  always @(negedge clk) begin
    scan_exp_t s;
    if (bus.an_out !== prev_an) begin
      if (scan_q.size() > 0) begin
        s = scan_q.pop_front();
        chk("scan_an", 32'(bus.an_out), 32'(s.an));
        chk("scan_seg", 32'(bus.seg_out), 32'(s.seg));
        chk("scan_hold", 32'(hold), 32'd4);
      end
      hold    = 1;
      prev_an = bus.an_out;
    end else begin
      hold++;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset         = 1'b1;
    bus.nibble_in = 4'h0;
    bus.enter     = 1'b0;
    bus.clear     = 1'b0;
    bus.opcode_in = 4'h0;
    bus.cin_in    = 1'b0;
    bus.view_sel  = 2'd0;
    repeat (2) step();
    reset = 1'b0;

    chk("rst_state", 32'(bus.state_out), 32'h0);
    chk("rst_a", 32'(bus.alu_a), 32'h0);
    chk("rst_b", 32'(bus.alu_b), 32'h0);
    chk("rst_res", 32'(bus.result_out), 32'h0);
    chk("rst_valid", 32'(bus.result_valid), 32'h0);
    chk("rst_an", 32'(bus.an_out), 32'b1110);
    chk("rst_seg", 32'(bus.seg_out), 32'(S0));

    enter_nib(4'h1);
    enter_nib(4'h2);
    enter_nib(4'h3);
    enter_nib(4'h4);
    chk("a_entry", 32'(bus.alu_a), 32'h1234);
    chk("a_state", 32'(bus.state_out), 32'h1);
    chk("a_b_zero", 32'(bus.alu_b), 32'h0);

    bus.opcode_in = 4'h5;
    bus.cin_in    = 1'b1;
    enter_nib(4'hA);
    enter_nib(4'hB);
    enter_nib(4'hC);
    res_q.push_back('{res: 16'hBE02, flg: 5'b00010});
    enter_nib(4'hD);
    chk("b_entry", 32'(bus.alu_b), 32'hABCD);
    chk("op_reg", 32'(bus.alu_opcode), 32'h5);
    chk("cin_reg", 32'(bus.alu_cin), 32'h1);
    chk("exec_state", 32'(bus.state_out), 32'h2);
    chk("exec_valid", 32'(bus.result_valid), 32'h0);
    step();
    chk("show_valid", 32'(bus.result_valid), 32'h1);
    chk("show_res", 32'(bus.result_out), 32'hBE02);
    chk("show_flg", 32'(bus.flags_out), 32'h02);
    chk("show_state", 32'(bus.state_out), 32'h3);

    bus.view_sel = 2'd3;
    wait_an(4'b0111, "scan_sync");
    step();
    scan_q.push_back('{an: 4'b1110, seg: S2});
    scan_q.push_back('{an: 4'b1101, seg: S0});
    scan_q.push_back('{an: 4'b1011, seg: SE});
    scan_q.push_back('{an: 4'b0111, seg: SB});
    for (int i = 0; i < 40; i++) begin
      if (scan_q.size() == 0) break;
      step();
    end
    chk("scan_drain", 32'(scan_q.size()), 32'd0);

    wait_an(4'b1110, "view_sync");
    chk("view_res_d0", 32'(bus.seg_out), 32'(S2));
    bus.view_sel = 2'd1;
    step();
    chk("view_a_an", 32'(bus.an_out), 32'b1110);
    chk("view_a_d0", 32'(bus.seg_out), 32'(S4));

    bus.view_sel = 2'd0;
    enter_nib(4'h7);
    chk("rs_a", 32'(bus.alu_a), 32'h0007);
    chk("rs_b", 32'(bus.alu_b), 32'h0);
    chk("rs_valid", 32'(bus.result_valid), 32'h0);
    chk("rs_state", 32'(bus.state_out), 32'h0);
    chk("rs_keep_res", 32'(bus.result_out), 32'hBE02);

    enter_nib(4'h0);
    enter_nib(4'h0);
    enter_nib(4'h1);
    chk("rs_a_full", 32'(bus.alu_a), 32'h7001);
    chk("rs_to_b", 32'(bus.state_out), 32'h1);
    enter_nib(4'h1);
    enter_nib(4'h2);
    bus.nibble_in = 4'h5;
    bus.clear     = 1'b1;
    bus.enter     = 1'b1;
    step();
    bus.clear = 1'b0;
    bus.enter = 1'b0;
    chk("clr_state", 32'(bus.state_out), 32'h0);
    chk("clr_a", 32'(bus.alu_a), 32'h0);
    chk("clr_b", 32'(bus.alu_b), 32'h0);
    chk("clr_res", 32'(bus.result_out), 32'h0);
    chk("clr_flg", 32'(bus.flags_out), 32'h0);
    chk("clr_valid", 32'(bus.result_valid), 32'h0);
    chk("clr_keep_op", 32'(bus.alu_opcode), 32'h5);
    chk("clr_keep_cin", 32'(bus.alu_cin), 32'h1);

    enter_nib(4'h0);
    enter_nib(4'h0);
    enter_nib(4'h0);
    enter_nib(4'h1);
    bus.opcode_in = 4'h0;
    bus.cin_in    = 1'b0;
    enter_nib(4'h0);
    enter_nib(4'h0);
    enter_nib(4'h0);
    res_q.push_back('{res: 16'h0003, flg: 5'b00010});
    enter_nib(4'h2);
    chk("ex2_state", 32'(bus.state_out), 32'h2);
    bus.nibble_in = 4'hF;
    bus.enter     = 1'b1;
    step();
    bus.enter = 1'b0;
    chk("ex2_show", 32'(bus.state_out), 32'h3);
    chk("ex2_valid", 32'(bus.result_valid), 32'h1);
    chk("ex2_res", 32'(bus.result_out), 32'h0003);
    chk("ex2_a", 32'(bus.alu_a), 32'h0001);
    chk("ex2_b", 32'(bus.alu_b), 32'h0002);
    step();
    chk("ex2_hold", 32'(bus.state_out), 32'h3);
    chk("res_drain", 32'(res_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
